// File: rtl/dll_train_ctrl.sv
// dll_train_ctrl: sweeps DLL adj, finds the longest passing window, programs its centre.
module dll_train_ctrl #(
  parameter int MADJ          = 64,
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 256,
  parameter int SETTLE        = 2,
  parameter int SAMPLE_CYCLES = 16,
  parameter int MIN_WINDOW    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_start,
  input  logic       io_lock,
  input  logic       io_data_ok,
  output logic [7:0] io_adj,
  output logic [7:0] io_madj,
  output logic       io_dll_reset,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_fail,
  output logic [1:0] io_err,
  output logic [7:0] io_win_start,
  output logic [8:0] io_win_len
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_DRST   = 4'd1;
  localparam logic [3:0] S_WLOCK  = 4'd2;
  localparam logic [3:0] S_SAMPLE = 4'd3;
  localparam logic [3:0] S_STEP   = 4'd4;
  localparam logic [3:0] S_CENTER = 4'd5;
  localparam logic [3:0] S_CLOCK  = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_FAIL   = 4'd8;
  localparam logic [7:0] ADJ_TOP  = 8'(MADJ - 1);
  logic [3:0]  state_q, state_d;
  logic [7:0]  adj_q, adj_d, cur_start_q, cur_start_d, best_start_q, best_start_d, win_start_q, win_start_d;
  logic [8:0]  cur_len_q, cur_len_d, best_len_q, best_len_d, win_len_q, win_len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  logic        dll_reset_q, dll_reset_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d, pass_q, pass_d;
  logic        lock_ok, tout, close, fin;
  logic [8:0]  run_len;
  logic [7:0]  run_start;
  assign lock_ok   = (cnt_q >= 16'(SETTLE)) && io_lock;
  assign tout      = cnt_q == 16'(LOCK_TIMEOUT - 1);
  // Run including the current step; a pass at the top adj still closes the run.
  assign run_len   = pass_q ? cur_len_q + 9'd1 : cur_len_q;
  assign run_start = (pass_q && cur_len_q == 9'd0) ? adj_q : cur_start_q;
  assign close     = !pass_q || adj_q == ADJ_TOP;
  always_comb begin
    state_d      = state_q;
    adj_d        = adj_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    win_start_d  = win_start_q;
    win_len_d    = win_len_q;
    cnt_d        = cnt_q + 16'd1;
    err_d        = err_q;
    dll_reset_d  = dll_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    pass_d       = pass_q;
    fin          = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: if (io_start) begin
        state_d      = S_DRST;
        adj_d        = 8'd0;
        cur_start_d  = 8'd0;
        cur_len_d    = 9'd0;
        best_start_d = 8'd0;
        best_len_d   = 9'd0;
        err_d        = 2'd0;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        busy_d       = 1'b1;
        dll_reset_d  = 1'b1;
        cnt_d        = 16'd0;
      end
      S_DRST: if (cnt_q == 16'(RST_CYCLES - 1)) begin
        state_d     = S_WLOCK;
        dll_reset_d = 1'b0;
        cnt_d       = 16'd0;
      end
      S_WLOCK, S_CLOCK: if (lock_ok) begin
        state_d = state_q == S_WLOCK ? S_SAMPLE : S_DONE;
        cnt_d   = 16'd0;
        pass_d  = 1'b1;
        done_d  = state_q == S_CLOCK;
        busy_d  = state_q == S_WLOCK;
        fin     = state_q == S_CLOCK;
      end else if (tout) begin
        state_d = S_FAIL;
        err_d   = 2'd1;
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        fin     = 1'b1;
      end
      S_SAMPLE: begin
        pass_d = pass_q & io_data_ok & io_lock;
        if (cnt_q == 16'(SAMPLE_CYCLES - 1)) state_d = S_STEP;
      end
      S_STEP: begin
        cur_start_d = run_start;
        cur_len_d   = close ? 9'd0 : run_len;
        if (close && run_len > best_len_q) begin
          best_start_d = run_start;
          best_len_d   = run_len;
        end
        state_d = adj_q == ADJ_TOP ? S_CENTER : S_WLOCK;
        adj_d   = adj_q == ADJ_TOP ? adj_q : adj_q + 8'd1;
        cnt_d   = 16'd0;
      end
      S_CENTER: if (best_len_q < 9'(MIN_WINDOW)) begin
        state_d = S_FAIL;
        err_d   = 2'd2;
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        fin     = 1'b1;
      end else begin
        state_d = S_CLOCK;
        adj_d   = best_start_q + 8'(best_len_q >> 1);
        cnt_d   = 16'd0;
      end
      default: state_d = S_IDLE;
    endcase
    win_start_d = fin ? best_start_q : win_start_d;
    win_len_d   = fin ? best_len_q : win_len_d;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      adj_q        <= 8'd0;
      cur_start_q  <= 8'd0;
      cur_len_q    <= 9'd0;
      best_start_q <= 8'd0;
      best_len_q   <= 9'd0;
      win_start_q  <= 8'd0;
      win_len_q    <= 9'd0;
      cnt_q        <= 16'd0;
      err_q        <= 2'd0;
      dll_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adj_q        <= adj_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      win_start_q  <= win_start_d;
      win_len_q    <= win_len_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      dll_reset_q  <= dll_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      pass_q       <= pass_d;
    end
  end
  assign io_adj       = adj_q;
  assign io_madj      = 8'(MADJ);
  assign io_dll_reset = dll_reset_q;
  assign io_busy      = busy_q;
  assign io_done      = done_q;
  assign io_fail      = fail_q;
  assign io_err       = err_q;
  assign io_win_start = win_start_q;
  assign io_win_len   = win_len_q;
endmodule

// File: tb/tb_dll_train_ctrl.sv
// tb_dll_train_ctrl: randomized and directed checks of dll_train_ctrl against a window-scan model.
module tb_dll_train_ctrl;
  logic       clock = 0, reset = 1, io_start = 0, io_lock = 0, io_data_ok = 0;
  logic [7:0] io_adj, io_madj, io_win_start;
  logic       io_dll_reset, io_busy, io_done, io_fail;
  logic [1:0] io_err;
  logic [8:0] io_win_len;
  bit   [63:0] pass_map;
  bit          lock_en = 1;
  int          since = 0, n_cmp = 0, n_bad = 0;
  logic [7:0]  prev_adj = 0;

  dll_train_ctrl dut (.clock(clock), .reset(reset), .io_start(io_start), .io_lock(io_lock),
    .io_data_ok(io_data_ok), .io_adj(io_adj), .io_madj(io_madj), .io_dll_reset(io_dll_reset),
    .io_busy(io_busy), .io_done(io_done), .io_fail(io_fail), .io_err(io_err),
    .io_win_start(io_win_start), .io_win_len(io_win_len));

  always #5 clock = ~clock;

  // DLL model: locks a few cycles after any adj change or reset release; sampler passes per map.
  always @(negedge clock) begin
    if (io_dll_reset || io_adj != prev_adj) since = 0;
    else if (since < 1000) since = since + 1;
    prev_adj   = io_adj;
    io_lock    = lock_en && since >= 2;
    io_data_ok = pass_map[io_adj[5:0]];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); io_start = 1;
    @(negedge clock); io_start = 0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(io_done || io_fail) && k < 5000) begin @(negedge clock); k++; end
    chk({tag, "_end"}, int'(io_done || io_fail), 1);
  endtask

  task automatic wait_adj(input string tag, input int a);
    int k = 0;
    while (int'(io_adj) != a && k < 5000) begin @(negedge clock); k++; end
    chk({tag, "_reach"}, int'(io_adj), a);
  endtask

  // Longest run of passing adj values, earliest on ties; then the expected training outcome.
  task automatic check_model(input string tag);
    int cur = 0, cs = 0, bs = 0, bl = 0;
    for (int a = 0; a < 64; a++) begin
      if (pass_map[a]) begin
        if (cur == 0) cs = a;
        cur++;
      end else cur = 0;
      if (cur > bl) begin bl = cur; bs = cs; end
    end
    chk({tag, "_done"}, int'(io_done), int'(bl >= 4));
    chk({tag, "_fail"}, int'(io_fail), int'(bl < 4));
    chk({tag, "_err"}, int'(io_err), bl >= 4 ? 0 : 2);
    chk({tag, "_wstart"}, int'(io_win_start), bs);
    chk({tag, "_wlen"}, int'(io_win_len), bl);
    chk({tag, "_adj"}, int'(io_adj), bl >= 4 ? bs + bl / 2 : 63);
    chk({tag, "_busy"}, int'(io_busy), 0);
  endtask

  task automatic run_map(input string tag, input bit [63:0] m);
    pass_map = m;
    pulse_start();
    wait_end(tag);
    check_model(tag);
  endtask

  function automatic bit [63:0] range_map(input int lo, input int hi);
    bit [63:0] m = '0;
    for (int a = lo; a <= hi; a++) m[a] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_adj"}, int'(io_adj), 0);
    chk({tag, "_madj"}, int'(io_madj), 64);
    chk({tag, "_dllrst"}, int'(io_dll_reset), 1);
    chk({tag, "_busy"}, int'(io_busy), 0);
    chk({tag, "_done"}, int'(io_done), 0);
    chk({tag, "_fail"}, int'(io_fail), 0);
    chk({tag, "_err"}, int'(io_err), 0);
    chk({tag, "_wstart"}, int'(io_win_start), 0);
    chk({tag, "_wlen"}, int'(io_win_len), 0);
  endtask

  initial begin
    bit [63:0] m;
    bit        v;
    int        n, k;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 0;
    run_map("all", '1);
    run_map("mid", range_map(10, 20));
    run_map("two", range_map(5, 8) | range_map(30, 45));
    run_map("tie", range_map(0, 3) | range_map(10, 13));
    run_map("top", range_map(50, 63));
    run_map("short", range_map(20, 22));
    // Lock never arrives: failure lands exactly LOCK_TIMEOUT cycles into the first WLOCK.
    lock_en = 0;
    pass_map = '1;
    pulse_start();
    k = 0;
    while (io_dll_reset && k < 100) begin @(negedge clock); k++; end
    chk("to_drst", int'(io_dll_reset), 0);
    n = 0;
    while (!io_fail && n < 1000) begin @(negedge clock); n++; end
    chk("to_cycles", n, 256);
    chk("to_err", int'(io_err), 1);
    chk("to_adj", int'(io_adj), 0);
    chk("to_busy", int'(io_busy), 0);
    lock_en = 1;
    // A start pulse mid-sweep must not disturb the sweep.
    pass_map = range_map(12, 40);
    pulse_start();
    wait_adj("ign", 30);
    pulse_start();
    repeat (3) @(negedge clock);
    chk("ign_adj", int'(io_adj >= 8'd30), 1);
    chk("ign_busy", int'(io_busy), 1);
    chk("ign_dllrst", int'(io_dll_reset), 0);
    wait_end("ign");
    check_model("ign");
    // Reset in the middle of sampling adj 20.
    pass_map = '1;
    pulse_start();
    wait_adj("mrst", 20);
    repeat (8) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check_reset_vals("mrst");
    reset = 0;
    for (int t = 0; t < 5; t++) begin
      v = $urandom_range(0, 1);
      for (int a = 0; a < 64; a++) begin
        if ($urandom_range(0, 7) == 0) v = ~v;
        m[a] = v;
      end
      run_map($sformatf("rnd%0d", t), m);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
